// File: rtl/mips_pkg.sv
// Shared MIPS definitions for the data-memory access path.
// Holds the load/store width encodings (identical to the decoder's) and the
// state encoding of the memory-access sequencer.
// No ports (package).
package mips_pkg;

  localparam logic [2:0] LOAD_LB  = 3'd0;
  localparam logic [2:0] LOAD_LBU = 3'd1;
  localparam logic [2:0] LOAD_LH  = 3'd2;
  localparam logic [2:0] LOAD_LHU = 3'd3;
  localparam logic [2:0] LOAD_LW  = 3'd4;

  localparam logic [1:0] STORE_SB = 2'd0;
  localparam logic [1:0] STORE_SH = 2'd1;
  localparam logic [1:0] STORE_SW = 2'd2;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    DONE = 2'd2
  } mem_state_t;

endpackage

// File: rtl/load_extend.sv
// Combinational load-data extraction.
// Picks the byte/half addressed by addr_lo_i out of the bus word and sign- or
// zero-extends it according to load_type_i. Codes 5..7 behave as LW.
// Ports:
//   rdata_i     [31:0] word read from the bus
//   addr_lo_i   [1:0]  byte offset of the access
//   load_type_i [2:0]  LB/LBU/LH/LHU/LW
//   result_o    [31:0] extended load result
module load_extend
  import mips_pkg::*;
(
  input  logic [31:0] rdata_i,
  input  logic [1:0]  addr_lo_i,
  input  logic [2:0]  load_type_i,
  output logic [31:0] result_o
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  always_comb begin
    case (addr_lo_i)
      2'd0:    byte_sel = rdata_i[7:0];
      2'd1:    byte_sel = rdata_i[15:8];
      2'd2:    byte_sel = rdata_i[23:16];
      default: byte_sel = rdata_i[31:24];
    endcase
    // Half accesses only look at addr[1]; addr[0] is either checked upstream
    // or deliberately ignored.
    half_sel = addr_lo_i[1] ? rdata_i[31:16] : rdata_i[15:0];

    case (load_type_i)
      LOAD_LB:  result_o = {{24{byte_sel[7]}}, byte_sel};
      LOAD_LBU: result_o = {24'd0, byte_sel};
      LOAD_LH:  result_o = {{16{half_sel[15]}}, half_sel};
      LOAD_LHU: result_o = {16'd0, half_sel};
      default:  result_o = rdata_i;
    endcase
  end

endmodule

// File: rtl/store_align.sv
// Combinational store alignment.
// Produces little-endian byte enables and lane-replicated write data so the
// slave can simply write the enabled lanes. Code 3 behaves as SW.
// Ports:
//   wdata_i      [31:0] store data (rt)
//   addr_lo_i    [1:0]  byte offset of the access
//   store_type_i [1:0]  SB/SH/SW
//   be_o         [3:0]  byte enables
//   wdata_o      [31:0] replicated store data
module store_align
  import mips_pkg::*;
(
  input  logic [31:0] wdata_i,
  input  logic [1:0]  addr_lo_i,
  input  logic [1:0]  store_type_i,
  output logic [3:0]  be_o,
  output logic [31:0] wdata_o
);

  always_comb begin
    case (store_type_i)
      STORE_SB: begin
        be_o    = 4'b0001 << addr_lo_i;
        wdata_o = {4{wdata_i[7:0]}};
      end
      STORE_SH: begin
        be_o    = addr_lo_i[1] ? 4'b1100 : 4'b0011;
        wdata_o = {2{wdata_i[15:0]}};
      end
      default: begin
        be_o    = 4'b1111;
        wdata_o = wdata_i;
      end
    endcase
  end

endmodule

// File: rtl/mem_access_ctrl.sv
// MEM-stage load/store sequencer for a variable-latency req/ack data bus.
// Stalls the pipeline while an access is in flight, forms byte enables and
// replicated write data for stores, and extends load data.
// Optional feature: define MEM_ALIGN_CHECK_EN to complete misaligned half/word
// accesses immediately with misalign=1 and no bus request.
//
// Bus handshake: bus_req rises on entry to WAIT and stays high, with
// bus_we/bus_addr/bus_be/bus_wdata held constant, until the cycle in which
// bus_ack is sampled high (bus_rdata is valid in that same cycle). bus_ack is
// ignored outside WAIT. A request may be withdrawn without ack by reset or
// timeout.
//
// Ports:
//   clk, rst                 clock, synchronous active-high reset
//   mem_valid/read/write     MEM-stage request qualifiers (write wins)
//   load_type, store_type    access width encodings (mips_pkg)
//   addr, wdata              effective address and store data
//   stall                    freeze IF..MEM pipeline registers
//   done, load_data          completion pulse and extended load result
//   bus_err, misalign        completion status, valid with done
//   bus_req..bus_wdata       request side of the data bus
//   bus_ack, bus_rdata       response side of the data bus
//   dbg_state                current sequencer state (mem_state_t)
module mem_access_ctrl
  import mips_pkg::*;
#(
  parameter int TIMEOUT   = 64,
  parameter int TIMEOUT_W = 8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        mem_valid,
  input  logic        mem_read,
  input  logic        mem_write,
  input  logic [2:0]  load_type,
  input  logic [1:0]  store_type,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  output logic        stall,
  output logic        done,
  output logic [31:0] load_data,
  output logic        bus_err,
  output logic        misalign,
  output logic        bus_req,
  output logic        bus_we,
  output logic [31:0] bus_addr,
  output logic [3:0]  bus_be,
  output logic [31:0] bus_wdata,
  input  logic        bus_ack,
  input  logic [31:0] bus_rdata,
  output logic [1:0]  dbg_state
);

  localparam logic [TIMEOUT_W-1:0] CNT_MAX  = TIMEOUT_W'(TIMEOUT);
  localparam logic [TIMEOUT_W-1:0] CNT_LAST = TIMEOUT_W'(TIMEOUT - 1);

  mem_state_t state_q, state_d;
  logic                 we_q, we_d;
  logic [31:0]          bus_addr_q, bus_addr_d;
  logic [1:0]           addr_lo_q, addr_lo_d;
  logic [2:0]           ltype_q, ltype_d;
  logic [3:0]           be_q, be_d;
  logic [31:0]          wdata_q, wdata_d;
  logic [31:0]          load_data_q, load_data_d;
  logic                 err_q, err_d;
  logic [TIMEOUT_W-1:0] cnt_q, cnt_d;

  logic        req_start;
  logic        misaligned;
  logic        timeout_hit;
  logic [3:0]  st_be;
  logic [31:0] st_wdata;
  logic [31:0] ld_ext;

  store_align u_store_align (
    .wdata_i      (wdata),
    .addr_lo_i    (addr[1:0]),
    .store_type_i (store_type),
    .be_o         (st_be),
    .wdata_o      (st_wdata)
  );

  // Uses the registered offset/type so the result matches the issued request.
  load_extend u_load_extend (
    .rdata_i     (bus_rdata),
    .addr_lo_i   (addr_lo_q),
    .load_type_i (ltype_q),
    .result_o    (ld_ext)
  );

  assign req_start = (state_q == IDLE) && mem_valid && (mem_read || mem_write);

  // cnt_q counts completed WAIT cycles, so the last allowed cycle is TIMEOUT-1.
  assign timeout_hit = (TIMEOUT != 0) && (cnt_q == CNT_LAST);

`ifdef MEM_ALIGN_CHECK_EN
  logic mis_q, mis_d;

  always_comb begin
    misaligned = 1'b0;
    if (mem_write) begin
      case (store_type)
        STORE_SB: misaligned = 1'b0;
        STORE_SH: misaligned = addr[0];
        default:  misaligned = |addr[1:0];
      endcase
    end else begin
      case (load_type)
        LOAD_LB, LOAD_LBU: misaligned = 1'b0;
        LOAD_LH, LOAD_LHU: misaligned = addr[0];
        default:           misaligned = |addr[1:0];
      endcase
    end
  end

  assign misalign = (state_q == DONE) && mis_q;
`else
  assign misaligned = 1'b0;
  assign misalign   = 1'b0;
`endif

  always_comb begin
    state_d     = state_q;
    we_d        = we_q;
    bus_addr_d  = bus_addr_q;
    addr_lo_d   = addr_lo_q;
    ltype_d     = ltype_q;
    be_d        = be_q;
    wdata_d     = wdata_q;
    load_data_d = load_data_q;
    err_d       = err_q;
    cnt_d       = cnt_q;
`ifdef MEM_ALIGN_CHECK_EN
    mis_d       = mis_q;
`endif

    case (state_q)
      IDLE: begin
        if (req_start) begin
          err_d = 1'b0;
`ifdef MEM_ALIGN_CHECK_EN
          mis_d = misaligned;
`endif
          if (misaligned) begin
            // Complete without touching the bus, so nothing is written.
            state_d     = DONE;
            load_data_d = 32'd0;
          end else begin
            state_d    = WAIT;
            we_d       = mem_write;
            bus_addr_d = {addr[31:2], 2'b00};
            addr_lo_d  = addr[1:0];
            ltype_d    = load_type;
            be_d       = mem_write ? st_be : 4'b1111;
            wdata_d    = st_wdata;
            cnt_d      = '0;
          end
        end
      end
      WAIT: begin
        if (bus_ack) begin
          state_d     = DONE;
          load_data_d = ld_ext;
        end else if (timeout_hit) begin
          state_d     = DONE;
          err_d       = 1'b1;
          load_data_d = 32'd0;
        end else if (cnt_q != CNT_MAX) begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      we_q        <= 1'b0;
      bus_addr_q  <= 32'd0;
      addr_lo_q   <= 2'd0;
      ltype_q     <= 3'd0;
      be_q        <= 4'd0;
      wdata_q     <= 32'd0;
      load_data_q <= 32'd0;
      err_q       <= 1'b0;
      cnt_q       <= '0;
`ifdef MEM_ALIGN_CHECK_EN
      mis_q       <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      we_q        <= we_d;
      bus_addr_q  <= bus_addr_d;
      addr_lo_q   <= addr_lo_d;
      ltype_q     <= ltype_d;
      be_q        <= be_d;
      wdata_q     <= wdata_d;
      load_data_q <= load_data_d;
      err_q       <= err_d;
      cnt_q       <= cnt_d;
`ifdef MEM_ALIGN_CHECK_EN
      mis_q       <= mis_d;
`endif
    end
  end

  assign stall     = req_start || (state_q == WAIT);
  assign done      = (state_q == DONE);
  assign bus_err   = (state_q == DONE) && err_q;
  assign bus_req   = (state_q == WAIT);
  assign bus_we    = we_q;
  assign bus_addr  = bus_addr_q;
  assign bus_be    = be_q;
  assign bus_wdata = wdata_q;
  assign load_data = load_data_q;
  assign dbg_state = state_q;

endmodule
